// File: rtl/sar_pkg.sv
// Shared types and widths for the successive-approximation search block.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Settle counter holds 1..7; probe counter reports up to 7 probes.
  localparam int SETTLE_W = 3;
  localparam int PROBE_W  = 3;

  // True when exactly one of the three comparator flags is set.
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator handshake and search result bundle for sar_search.
interface sar_search_if #(
  parameter int WIDTH = 4
);
  import sar_pkg::*;

  logic                 start;
  logic                 agtb;
  logic                 aeqb;
  logic                 altb;
  logic [WIDTH-1:0]     guess;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [WIDTH-1:0]     result;
  logic [PROBE_W-1:0]   steps;

  modport master (
    output start, agtb, aeqb, altb,
    input  guess, busy, done, error, result, steps
  );

  modport slave (
    input  start, agtb, aeqb, altb,
    output guess, busy, done, error, result, steps
  );

endinterface

// File: rtl/sar_bounds.sv
// Combinational bound narrowing and next-guess arithmetic for one probe.
// Bounds are one bit wider than the guess so that guess+1 at the top of the
// range and guess-1 at the bottom can be detected as an empty interval.
module sar_bounds
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   lo,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] guess,
  input  logic             agtb,
  input  logic             aeqb,
  input  logic             altb,
  output logic [WIDTH:0]   next_lo,
  output logic [WIDTH:0]   next_hi,
  output logic [WIDTH-1:0] next_guess,
  output logic             found,
  output logic             fail
);

  logic [WIDTH:0] guess_ext;
  logic [WIDTH:0] sum;

  assign guess_ext = {1'b0, guess};

  // Narrow the interval on the flag that fired and flag an empty or inconsistent result.
  always_comb begin
    next_lo = lo;
    next_hi = hi;
    found   = 1'b0;
    fail    = 1'b0;
    if (!one_hot3(agtb, aeqb, altb)) begin
      fail = 1'b1;
    end else if (aeqb) begin
      found = 1'b1;
    end else if (agtb) begin
      next_hi = guess_ext - (WIDTH+1)'(1);
      fail    = (guess_ext == '0) || (lo > next_hi);
    end else begin
      next_lo = guess_ext + (WIDTH+1)'(1);
      fail    = (next_lo > hi);
    end
    sum        = next_lo + next_hi;
    next_guess = WIDTH'(sum >> 1);
  end

endmodule

// File: rtl/sar_search.sv
// Binary search of an external target through a registered probe value and
// an external magnitude comparator; each probe is held SETTLE cycles before
// the comparator flags are trusted.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);

  state_t               state_q, state_d;
  logic [WIDTH:0]       lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0]     guess_q, guess_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [PROBE_W-1:0]   steps_q, steps_d;
  logic [PROBE_W-1:0]   probe_q, probe_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 error_q, error_d;

  logic [WIDTH:0]       b_lo, b_hi;
  logic [WIDTH-1:0]     b_guess;
  logic                 b_found, b_fail;

  sar_bounds #(.WIDTH(WIDTH)) u_bounds (
    .lo         (lo_q),
    .hi         (hi_q),
    .guess      (guess_q),
    .agtb       (bus.agtb),
    .aeqb       (bus.aeqb),
    .altb       (bus.altb),
    .next_lo    (b_lo),
    .next_hi    (b_hi),
    .next_guess (b_guess),
    .found      (b_found),
    .fail       (b_fail)
  );

  // Next-state and datapath decisions for the search FSM.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    probe_d  = probe_q;
    settle_d = settle_q;
    error_d  = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          lo_d     = '0;
          hi_d     = {1'b0, {WIDTH{1'b1}}};
          guess_d  = {1'b0, {(WIDTH-1){1'b1}}};
          probe_d  = '0;
          settle_d = SETTLE_W'(SETTLE);
          error_d  = 1'b0;
          state_d  = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (settle_q == SETTLE_W'(1)) begin
          probe_d = probe_q + PROBE_W'(1);
          if (b_fail || b_found) begin
            result_d = guess_q;
            steps_d  = probe_q + PROBE_W'(1);
            error_d  = b_fail;
            state_d  = ST_DONE;
          end else begin
            lo_d     = b_lo;
            hi_d     = b_hi;
            guess_d  = b_guess;
            settle_d = SETTLE_W'(SETTLE);
          end
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      probe_q  <= '0;
      settle_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      probe_q  <= probe_d;
      settle_q <= settle_d;
      error_q  <= error_d;
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == ST_PROBE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.error  = error_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;

endmodule

// File: tb/tb_sar_search.sv
// Closed-loop bench for sar_search: two instances (SETTLE=1 and SETTLE=3)
// each searching a target through a behavioural 4-bit comparator.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // 0 = honest comparator, 1 = agtb and aeqb forced, 2 = altb forced.
  int   target [2];
  int   mode   [2];
  logic start_r[2];

  typedef struct {
    int              idx;
    int              tgt;
    int              md;
    int              n;
    int              hold;
    logic [5:0][3:0] g;
    int              lat;
    int              res;
    int              err;
    int              steps;
  } vec_t;

  vec_t vecs[6];
  vec_t restart_vec;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(4)) bus1 ();
  sar_search_if #(.WIDTH(4)) bus3 ();

  sar_search #(.WIDTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sar_search #(.WIDTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus1.start = start_r[0];
  assign bus1.agtb  = (mode[0] == 1) ? 1'b1 : (mode[0] == 2) ? 1'b0 : (int'(bus1.guess) >  target[0]);
  assign bus1.aeqb  = (mode[0] == 1) ? 1'b1 : (mode[0] == 2) ? 1'b0 : (int'(bus1.guess) == target[0]);
  assign bus1.altb  = (mode[0] == 1) ? 1'b0 : (mode[0] == 2) ? 1'b1 : (int'(bus1.guess) <  target[0]);

  assign bus3.start = start_r[1];
  assign bus3.agtb  = (mode[1] == 1) ? 1'b1 : (mode[1] == 2) ? 1'b0 : (int'(bus3.guess) >  target[1]);
  assign bus3.aeqb  = (mode[1] == 1) ? 1'b1 : (mode[1] == 2) ? 1'b0 : (int'(bus3.guess) == target[1]);
  assign bus3.altb  = (mode[1] == 1) ? 1'b0 : (mode[1] == 2) ? 1'b1 : (int'(bus3.guess) <  target[1]);

  function automatic int get_guess(input int idx);
    return (idx == 0) ? int'(bus1.guess) : int'(bus3.guess);
  endfunction
  function automatic int get_result(input int idx);
    return (idx == 0) ? int'(bus1.result) : int'(bus3.result);
  endfunction
  function automatic int get_steps(input int idx);
    return (idx == 0) ? int'(bus1.steps) : int'(bus3.steps);
  endfunction
  function automatic int get_busy(input int idx);
    return (idx == 0) ? int'(bus1.busy) : int'(bus3.busy);
  endfunction
  function automatic int get_done(input int idx);
    return (idx == 0) ? int'(bus1.done) : int'(bus3.done);
  endfunction
  function automatic int get_error(input int idx);
    return (idx == 0) ? int'(bus1.error) : int'(bus3.error);
  endfunction

  function automatic logic [5:0][3:0] pack_g(input int a, input int b, input int c,
                                             input int d, input int e, input int f);
    logic [5:0][3:0] g;
    g[0] = 4'(a); g[1] = 4'(b); g[2] = 4'(c);
    g[3] = 4'(d); g[4] = 4'(e); g[5] = 4'(f);
    return g;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    checkOutput({tag, "/guess"},  get_guess(idx),  0);
    checkOutput({tag, "/busy"},   get_busy(idx),   0);
    checkOutput({tag, "/done"},   get_done(idx),   0);
    checkOutput({tag, "/error"},  get_error(idx),  0);
    checkOutput({tag, "/result"}, get_result(idx), 0);
    checkOutput({tag, "/steps"},  get_steps(idx),  0);
  endtask

  // One start pulse, then follow the probe sequence cycle by cycle until done.
  task automatic applyStimulus(input vec_t v, input int id);
    int cyc;
    int n;
    int seq_bad;
    target[v.idx] = v.tgt;
    mode[v.idx]   = v.md;
    @(negedge clk);
    start_r[v.idx] = 1'b1;
    @(negedge clk);
    start_r[v.idx] = 1'b0;
    cyc = 0; n = 0; seq_bad = 0;
    while (get_done(v.idx) == 0 && cyc < 40) begin
      if (n < v.n * v.hold) begin
        if (get_guess(v.idx) != int'(v.g[n / v.hold])) seq_bad++;
      end else begin
        seq_bad++;
      end
      if (get_busy(v.idx) == 0) seq_bad++;
      n++;
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("v%0d/latency", id),   cyc, v.lat);
    checkOutput($sformatf("v%0d/guessSeq", id),  seq_bad, 0);
    checkOutput($sformatf("v%0d/result", id),    get_result(v.idx), v.res);
    checkOutput($sformatf("v%0d/error", id),     get_error(v.idx), v.err);
    checkOutput($sformatf("v%0d/steps", id),     get_steps(v.idx), v.steps);
    checkOutput($sformatf("v%0d/busyInDone", id), get_busy(v.idx), 0);
    checkOutput($sformatf("v%0d/guessHeld", id), get_guess(v.idx), int'(v.g[v.n - 1]));
    @(negedge clk);
    checkOutput($sformatf("v%0d/donePulse", id), get_done(v.idx), 0);
    checkOutput($sformatf("v%0d/idleBusy", id),  get_busy(v.idx), 0);
    checkOutput($sformatf("v%0d/idleResult", id), get_result(v.idx), v.res);
  endtask

  // Safety net so a hung handshake still terminates the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int cyc;
    int g1;
    int saw_done;

    rst_n = 1'b0;
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    target[0] = 0; target[1] = 0;
    mode[0] = 0; mode[1] = 0;

    vecs[0] = '{idx:0, tgt:10, md:0, n:4, hold:1, g:pack_g(7, 11, 9, 10, 0, 0),   lat:4,  res:10, err:0, steps:4};
    vecs[1] = '{idx:0, tgt:15, md:0, n:5, hold:1, g:pack_g(7, 11, 13, 14, 15, 0), lat:5,  res:15, err:0, steps:5};
    vecs[2] = '{idx:0, tgt:0,  md:0, n:4, hold:1, g:pack_g(7, 3, 1, 0, 0, 0),     lat:4,  res:0,  err:0, steps:4};
    vecs[3] = '{idx:1, tgt:10, md:0, n:4, hold:3, g:pack_g(7, 11, 9, 10, 0, 0),   lat:12, res:10, err:0, steps:4};
    vecs[4] = '{idx:0, tgt:3,  md:1, n:1, hold:1, g:pack_g(7, 0, 0, 0, 0, 0),     lat:1,  res:7,  err:1, steps:1};
    vecs[5] = '{idx:0, tgt:3,  md:2, n:5, hold:1, g:pack_g(7, 11, 13, 14, 15, 0), lat:5,  res:15, err:1, steps:5};
    restart_vec = '{idx:0, tgt:5, md:0, n:3, hold:1, g:pack_g(7, 3, 5, 0, 0, 0),  lat:3,  res:5,  err:0, steps:3};

    repeat (3) @(negedge clk);
    check_idle(0, "reset1");
    check_idle(1, "reset3");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    // start held high through a whole search must not restart it.
    target[0] = 10; mode[0] = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    cyc = 0; g1 = 0;
    while (get_done(0) == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) g1 = get_guess(0);
    end
    checkOutput("holdStart/latency", cyc, 4);
    checkOutput("holdStart/guess1", g1, 11);
    checkOutput("holdStart/result", get_result(0), 10);
    @(negedge clk);
    start_r[0] = 1'b0;
    checkOutput("holdStart/idleAfterDone", get_busy(0), 0);
    @(negedge clk);
    checkOutput("holdStart/noRestart", get_busy(0), 0);

    // Reset asserted during the second probe abandons the search silently.
    target[0] = 10; mode[0] = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    checkOutput("rstMid/guessBefore", get_guess(0), 11);
    rst_n = 1'b0;
    #1;
    check_idle(0, "rstMid");
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (get_done(0) != 0) saw_done = 1;
    end
    checkOutput("rstMid/noDone", saw_done, 0);
    rst_n = 1'b1;
    applyStimulus(restart_vec, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
